id_hazard_scoreboard: RTL and testbench

Parametrised hazard and stall unit for the ID stage. It replaces the fixed 2-bit stall countdown with a per-register scoreboard of in-flight write latencies. It also tracks the HI/LO pending state and a multi-cycle multiply/divide busy counter. It sits beside the control unit: it consumes decoded operand and destination info for the ID instruction and produces the stall signal that freezes the PC and IF/ID and bubbles ID/EXE.

---
 rtl/id_hazard_scoreboard_if.sv | 39 +++
 rtl/id_hazard_scoreboard.sv | 146 ++++++++++++++
 tb/tb_id_hazard_scoreboard.sv | 289 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/id_hazard_scoreboard_if.sv
// Handshake bundle between the ID-stage control unit and the hazard scoreboard.
// The control unit (master) presents decoded operand/destination info for the
// instruction sitting in ID; the scoreboard (slave) answers with stall/issue
// and exposes its pending state for observation.
interface id_hazard_scoreboard_if #(
  parameter int NUM_REGS = 32,
  parameter int ADDR_W   = 5,
  parameter int CNT_W    = 3
);
  logic                id_valid;
  logic                flush;
  logic [ADDR_W-1:0]   rs_addr;
  logic                rs_use;
  logic [ADDR_W-1:0]   rt_addr;
  logic                rt_use;
  logic [ADDR_W-1:0]   rd_addr;
  logic                rd_we;
  logic [CNT_W-1:0]    rd_lat;
  logic                hilo_use;
  logic                hilo_we;
  logic                md_start;
  logic                stall;
  logic                issue;
  logic                md_busy;
  logic [NUM_REGS-1:0] pending_mask;
  logic [31:0]         stall_cycles;

  modport master (
    output id_valid, flush, rs_addr, rs_use, rt_addr, rt_use,
           rd_addr, rd_we, rd_lat, hilo_use, hilo_we, md_start,
    input  stall, issue, md_busy, pending_mask, stall_cycles
  );

  modport slave (
    input  id_valid, flush, rs_addr, rs_use, rt_addr, rt_use,
           rd_addr, rd_we, rd_lat, hilo_use, hilo_we, md_start,
    output stall, issue, md_busy, pending_mask, stall_cycles
  );
endinterface

// File: rtl/id_hazard_scoreboard.sv
// ID-stage hazard scoreboard.
// Each GPR carries a countdown of cycles until its in-flight value becomes
// readable in ID; HI/LO and the multi-cycle mul/div unit have their own
// countdowns. A consumer whose source counter is nonzero stalls; an issuing
// producer (re)loads its destination counter, overriding that cycle's decrement.
module id_hazard_scoreboard #(
  parameter int NUM_REGS = 32,
  parameter int ADDR_W   = 5,
  parameter int CNT_W    = 3,
  parameter int HILO_LAT = 3,
  parameter int MD_LAT   = 8
) (
  input logic             clk,
  input logic             rst,
  id_hazard_scoreboard_if.slave sb
);

  // Table covers the whole address space so any rs/rt/rd indexes in range;
  // entries 0 and >= NUM_REGS are held at zero and never read as pending.
  localparam int DEPTH = 2 ** ADDR_W;
  localparam int HL_W  = (HILO_LAT > 0) ? $clog2(HILO_LAT + 1) : 1;
  localparam int MD_W  = (MD_LAT > 0) ? $clog2(MD_LAT + 1) : 1;

  localparam logic [ADDR_W-1:0] ADDR_ZERO = {ADDR_W{1'b0}};
  localparam logic [CNT_W-1:0]  CNT_ZERO  = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1'b1);
  localparam logic [HL_W-1:0]   HL_ZERO   = {HL_W{1'b0}};
  localparam logic [HL_W-1:0]   HL_ONE    = HL_W'(1'b1);
  localparam logic [HL_W-1:0]   HL_INIT   = HL_W'(HILO_LAT);
  localparam logic [MD_W-1:0]   MD_ZERO   = {MD_W{1'b0}};
  localparam logic [MD_W-1:0]   MD_ONE    = MD_W'(1'b1);
  localparam logic [MD_W-1:0]   MD_INIT   = MD_W'(MD_LAT);
  localparam logic [31:0]       SC_MAX    = 32'hFFFF_FFFF;

  logic [CNT_W-1:0]    cnt_r [DEPTH];
  logic [HL_W-1:0]     hilo_cnt_r;
  logic [MD_W-1:0]     md_cnt_r;
  logic [31:0]         stall_cycles_r;

  logic                rs_pend_s;
  logic                rt_pend_s;
  logic                raw_hz_s;
  logic                md_busy_s;
  logic                hl_hz_s;
  logic                live_s;
  logic                stall_s;
  logic                issue_s;
  logic                rd_wr_s;
  logic                md_go_s;
  logic                hl_go_s;
  logic [NUM_REGS-1:0] pending_mask_s;

  // Hazard detection and issue decision for the instruction in ID.
  always_comb begin
    rs_pend_s = sb.rs_use & (sb.rs_addr != ADDR_ZERO) & (cnt_r[sb.rs_addr] != CNT_ZERO);
    rt_pend_s = sb.rt_use & (sb.rt_addr != ADDR_ZERO) & (cnt_r[sb.rt_addr] != CNT_ZERO);
    raw_hz_s  = rs_pend_s | rt_pend_s;
    md_busy_s = (md_cnt_r != MD_ZERO);
    // While mul/div is busy HI/LO is not yet valid, and a second HI/LO writer
    // or mul/div launch would collide with the running operation.
    hl_hz_s   = (sb.hilo_use & ((hilo_cnt_r != HL_ZERO) | md_busy_s)) |
                ((sb.hilo_we | sb.md_start) & md_busy_s);
    // A flushed instruction is dead: it neither stalls nor issues.
    live_s    = sb.id_valid & ~sb.flush;
    stall_s   = live_s & (raw_hz_s | hl_hz_s);
    issue_s   = live_s & ~stall_s;
    rd_wr_s   = issue_s & sb.rd_we & (sb.rd_addr != ADDR_ZERO);
    md_go_s   = issue_s & sb.md_start;
    hl_go_s   = issue_s & sb.hilo_we;
  end

  // Per-register pending view; r0 is never pending.
  always_comb begin
    pending_mask_s = {NUM_REGS{1'b0}};
    for (int i = 1; i < NUM_REGS; i++) begin
      pending_mask_s[i] = (cnt_r[i] != CNT_ZERO);
    end
  end

  // GPR latency counters: issue reload wins over decrement of the same entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        cnt_r[i] <= CNT_ZERO;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if ((i == 32'sd0) || (i >= NUM_REGS)) begin
          cnt_r[i] <= CNT_ZERO;
        end else if (rd_wr_s && (sb.rd_addr == ADDR_W'(i))) begin
          cnt_r[i] <= sb.rd_lat;
        end else if (cnt_r[i] != CNT_ZERO) begin
          cnt_r[i] <= cnt_r[i] - CNT_ONE;
        end else begin
          cnt_r[i] <= cnt_r[i];
        end
      end
    end
  end

  // HI/LO readiness counter; a mul/div launch clears it since busy covers HI/LO.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hilo_cnt_r <= HL_ZERO;
    end else if (md_go_s) begin
      hilo_cnt_r <= HL_ZERO;
    end else if (hl_go_s) begin
      hilo_cnt_r <= HL_INIT;
    end else if (hilo_cnt_r != HL_ZERO) begin
      hilo_cnt_r <= hilo_cnt_r - HL_ONE;
    end else begin
      hilo_cnt_r <= hilo_cnt_r;
    end
  end

  // Multi-cycle mul/div busy counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      md_cnt_r <= MD_ZERO;
    end else if (md_go_s) begin
      md_cnt_r <= MD_INIT;
    end else if (md_cnt_r != MD_ZERO) begin
      md_cnt_r <= md_cnt_r - MD_ONE;
    end else begin
      md_cnt_r <= md_cnt_r;
    end
  end

  // Saturating count of stalled cycles for performance monitoring.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cycles_r <= 32'd0;
    end else if (stall_s && (stall_cycles_r != SC_MAX)) begin
      stall_cycles_r <= stall_cycles_r + 32'd1;
    end else begin
      stall_cycles_r <= stall_cycles_r;
    end
  end

  assign sb.stall        = stall_s;
  assign sb.issue        = issue_s;
  assign sb.md_busy      = md_busy_s;
  assign sb.pending_mask = pending_mask_s;
  assign sb.stall_cycles = stall_cycles_r;

endmodule

// File: tb/tb_id_hazard_scoreboard.sv
// Self-checking bench for id_hazard_scoreboard. The reference model tracks,
// per register, the absolute cycle at which its value becomes readable, plus
// the cycles at which HI/LO becomes readable and mul/div becomes free.
module tb_id_hazard_scoreboard;

  localparam int NUM_REGS = 32;
  localparam int ADDR_W   = 5;
  localparam int CNT_W    = 3;
  localparam int HILO_LAT = 3;
  localparam int MD_LAT   = 8;

  typedef struct packed {
    bit       v;
    bit       fl;
    bit [4:0] rs;
    bit       rsu;
    bit [4:0] rt;
    bit       rtu;
    bit [4:0] rd;
    bit       we;
    bit [2:0] lat;
    bit       hu;
    bit       hw;
    bit       ms;
  } op_t;

  logic clk;
  logic rst;

  id_hazard_scoreboard_if #(.NUM_REGS(NUM_REGS), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) sb_if ();

  id_hazard_scoreboard #(
    .NUM_REGS(NUM_REGS), .ADDR_W(ADDR_W), .CNT_W(CNT_W),
    .HILO_LAT(HILO_LAT), .MD_LAT(MD_LAT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .sb (sb_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  longint      cyc = 0;
  longint      rdy [NUM_REGS];
  longint      md_free = 0;
  longint      hilo_rdy = 0;
  logic [31:0] exp_sc = 32'd0;

  function automatic bit m_busy();
    return cyc < md_free;
  endfunction

  function automatic bit m_stall();
    bit raw;
    bit hl;
    raw = (sb_if.rs_use && sb_if.rs_addr != 5'd0 && cyc < rdy[sb_if.rs_addr]) ||
          (sb_if.rt_use && sb_if.rt_addr != 5'd0 && cyc < rdy[sb_if.rt_addr]);
    hl  = (sb_if.hilo_use && (cyc < hilo_rdy || m_busy())) ||
          ((sb_if.hilo_we || sb_if.md_start) && m_busy());
    return sb_if.id_valid && !sb_if.flush && (raw || hl);
  endfunction

  function automatic bit m_issue();
    return sb_if.id_valid && !sb_if.flush && !m_stall();
  endfunction

  function automatic logic [31:0] m_mask();
    logic [31:0] m;
    m = 32'd0;
    for (int i = 1; i < NUM_REGS; i++) m[i] = (cyc < rdy[i]);
    return m;
  endfunction

  // Advance the model at each rising edge using the inputs present in ID.
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) rdy[i] = 0;
      md_free  = 0;
      hilo_rdy = 0;
      exp_sc   = 32'd0;
    end else begin
      if (m_stall() && exp_sc != 32'hFFFF_FFFF) exp_sc = exp_sc + 32'd1;
      if (m_issue()) begin
        if (sb_if.rd_we && sb_if.rd_addr != 5'd0)
          rdy[sb_if.rd_addr] = cyc + longint'(sb_if.rd_lat) + 1;
        if (sb_if.md_start) begin
          md_free  = cyc + MD_LAT + 1;
          hilo_rdy = cyc + 1;
        end else if (sb_if.hilo_we) begin
          hilo_rdy = cyc + HILO_LAT + 1;
        end
      end
    end
    cyc = cyc + 1;
  end

  // ---------------- checking ----------------
  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic drive(input op_t o);
    sb_if.id_valid = o.v;
    sb_if.flush    = o.fl;
    sb_if.rs_addr  = o.rs;
    sb_if.rs_use   = o.rsu;
    sb_if.rt_addr  = o.rt;
    sb_if.rt_use   = o.rtu;
    sb_if.rd_addr  = o.rd;
    sb_if.rd_we    = o.we;
    sb_if.rd_lat   = o.lat;
    sb_if.hilo_use = o.hu;
    sb_if.hilo_we  = o.hw;
    sb_if.md_start = o.ms;
  endtask

  // One cycle: present op after the edge, compare everything at the falling edge.
  task automatic step(input op_t o);
    @(posedge clk);
    #1;
    drive(o);
    @(negedge clk);
    chk("stall", {31'd0, sb_if.stall}, {31'd0, m_stall()});
    chk("issue", {31'd0, sb_if.issue}, {31'd0, m_issue()});
    chk("md_busy", {31'd0, sb_if.md_busy}, {31'd0, m_busy()});
    chk("pending_mask", sb_if.pending_mask, m_mask());
    chk("stall_cycles", sb_if.stall_cycles, exp_sc);
  endtask

  function automatic op_t mk(input bit v, input bit fl, input int rs, input bit rsu,
                             input int rt, input bit rtu, input int rd, input bit we,
                             input int lat, input bit hu, input bit hw, input bit ms);
    op_t o;
    o.v = v; o.fl = fl; o.rs = 5'(rs); o.rsu = rsu; o.rt = 5'(rt); o.rtu = rtu;
    o.rd = 5'(rd); o.we = we; o.lat = 3'(lat); o.hu = hu; o.hw = hw; o.ms = ms;
    return o;
  endfunction

  function automatic op_t nop();
    return mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endfunction

  function automatic op_t wr(input int rd, input int lat);
    return mk(1, 0, 0, 0, 0, 0, rd, 1, lat, 0, 0, 0);
  endfunction

  function automatic op_t use_rs(input int rs);
    return mk(1, 0, rs, 1, 0, 0, 0, 0, 0, 0, 0, 0);
  endfunction

  function automatic op_t rand_op();
    op_t o;
    o.v   = ($urandom_range(0, 99) < 85);
    o.fl  = ($urandom_range(0, 99) < 8);
    o.rs  = 5'($urandom_range(0, 7));
    o.rsu = 1'($urandom_range(0, 1));
    o.rt  = 5'($urandom_range(0, 7));
    o.rtu = 1'($urandom_range(0, 1));
    o.rd  = 5'($urandom_range(0, 7));
    o.we  = ($urandom_range(0, 99) < 70);
    o.lat = 3'($urandom_range(0, 7));
    o.hu  = ($urandom_range(0, 99) < 10);
    o.hw  = ($urandom_range(0, 99) < 10);
    o.ms  = ($urandom_range(0, 99) < 4);
    return o;
  endfunction

  int  nst;
  op_t cur;
  bit  held_stall;

  initial begin
    rst = 1'b1;
    drive(nop());
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state.
    step(nop());
    chk("rst_stall", {31'd0, sb_if.stall}, 32'd0);
    chk("rst_issue", {31'd0, sb_if.issue}, 32'd0);
    chk("rst_md_busy", {31'd0, sb_if.md_busy}, 32'd0);
    chk("rst_mask", sb_if.pending_mask, 32'd0);
    chk("rst_sc", sb_if.stall_cycles, 32'd0);

    // Load-use: r8 latency 2 -> consumer stalls exactly 2 cycles.
    step(wr(8, 2));
    chk("lu_prod_issue", {31'd0, sb_if.issue}, 32'd1);
    step(use_rs(8));
    chk("lu_stall1", {31'd0, sb_if.stall}, 32'd1);
    chk("lu_mask1", sb_if.pending_mask, 32'h0000_0100);
    step(use_rs(8));
    chk("lu_stall2", {31'd0, sb_if.stall}, 32'd1);
    chk("lu_mask2", sb_if.pending_mask, 32'h0000_0100);
    step(use_rs(8));
    chk("lu_issue", {31'd0, sb_if.issue}, 32'd1);
    chk("lu_sc", sb_if.stall_cycles, 32'd2);
    chk("lu_mask3", sb_if.pending_mask, 32'd0);

    // r0 writes ignored; zero latency never stalls.
    step(wr(0, 5));
    step(use_rs(0));
    chk("r0_stall", {31'd0, sb_if.stall}, 32'd0);
    chk("r0_mask", sb_if.pending_mask, 32'd0);
    step(wr(9, 0));
    step(use_rs(9));
    chk("lat0_stall", {31'd0, sb_if.stall}, 32'd0);
    chk("lat0_mask", sb_if.pending_mask, 32'd0);

    // Mul/div then mfhi: 8 stall cycles, issue on the 9th.
    step(mk(1, 0, 1, 1, 2, 1, 0, 0, 0, 0, 0, 1));
    nst = 0;
    for (int k = 0; k < 8; k++) begin
      step(mk(1, 0, 0, 0, 0, 0, 2, 1, 0, 1, 0, 0));
      if (sb_if.stall === 1'b1) nst++;
    end
    chk("md_stall_cnt", nst, 32'd8);
    step(mk(1, 0, 0, 0, 0, 0, 2, 1, 0, 1, 0, 0));
    chk("md_mfhi_issue", {31'd0, sb_if.issue}, 32'd1);
    chk("md_idle", {31'd0, sb_if.md_busy}, 32'd0);

    // Second md_start while busy stalls; independent add does not.
    step(mk(1, 0, 1, 1, 2, 1, 0, 0, 0, 0, 0, 1));
    step(nop());
    step(nop());
    step(mk(1, 0, 1, 1, 2, 1, 0, 0, 0, 0, 0, 1));
    chk("md2_stall", {31'd0, sb_if.stall}, 32'd1);
    step(mk(1, 0, 1, 1, 2, 1, 3, 1, 0, 0, 0, 0));
    chk("add_issue", {31'd0, sb_if.issue}, 32'd1);
    repeat (8) step(nop());

    // Override: r5 lat 4 reloaded to lat 1 two cycles later.
    step(wr(5, 4));
    step(nop());
    step(wr(5, 1));
    step(use_rs(5));
    chk("ovr_stall", {31'd0, sb_if.stall}, 32'd1);
    step(use_rs(5));
    chk("ovr_issue", {31'd0, sb_if.issue}, 32'd1);

    // Flush priority: pending r3, flushed consumer writing r7.
    step(wr(3, 2));
    step(mk(1, 1, 3, 1, 0, 0, 7, 1, 6, 0, 0, 0));
    chk("fl_stall", {31'd0, sb_if.stall}, 32'd0);
    chk("fl_issue", {31'd0, sb_if.issue}, 32'd0);
    step(nop());
    chk("fl_mask", sb_if.pending_mask, 32'h0000_0008);
    step(nop());
    chk("fl_mask0", sb_if.pending_mask, 32'd0);

    // Async reset in the middle of a stall with mul/div busy.
    step(mk(1, 0, 1, 1, 2, 1, 0, 0, 0, 0, 0, 1));
    step(wr(8, 5));
    step(use_rs(8));
    chk("ar_pre_stall", {31'd0, sb_if.stall}, 32'd1);
    chk("ar_pre_mask", sb_if.pending_mask, 32'h0000_0100);
    #1 rst = 1'b1;
    #1;
    chk("ar_stall", {31'd0, sb_if.stall}, 32'd0);
    chk("ar_md_busy", {31'd0, sb_if.md_busy}, 32'd0);
    chk("ar_mask", sb_if.pending_mask, 32'd0);
    chk("ar_sc", sb_if.stall_cycles, 32'd0);
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;

    // Randomized traffic; a stalled instruction is usually held in ID.
    held_stall = 1'b0;
    cur = nop();
    for (int k = 0; k < 3000; k++) begin
      if (!(held_stall && $urandom_range(0, 99) < 80)) cur = rand_op();
      step(cur);
      held_stall = m_stall();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
